// File: rtl/dpram_copy_engine.sv
// Block-copy engine: reads a word range through RAM port A and writes it through port B at one word per cycle.
// Optional macro DPRAM_COPY_BACKWARD_EN: copy descending when dst_base > src_base, giving memmove-safe overlap.
module dpram_copy_engine #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              en_A,
    output logic [ADDR_W-1:0] addr_A,
    output logic [DATA_W-1:0] data_A,
    input  logic [DATA_W-1:0] out_A,
    output logic              en_B,
    output logic [ADDR_W-1:0] addr_B,
    output logic [DATA_W-1:0] data_B
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [ADDR_W:0]   MAX_LEN = (ADDR_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);

    state_t              state_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                en_a_reg;
    logic [ADDR_W-1:0]   addr_a_reg;
    logic [DATA_W-1:0]   data_a_reg;
    logic [ADDR_W-1:0]   rd_left_reg;
    logic                rd_valid_reg;
    logic [ADDR_W-1:0]   wr_addr_reg;
    logic                down_reg;
    logic                en_b_reg;
    logic [ADDR_W-1:0]   addr_b_reg;
    logic [DATA_W-1:0]   data_b_reg;

    logic [ADDR_W:0]     len_sat;
    logic [ADDR_W-1:0]   len_m1;
    logic                descend;
    logic [ADDR_W-1:0]   first_src;
    logic [ADDR_W-1:0]   first_dst;

    always_comb begin
        len_sat = (length > MAX_LEN) ? MAX_LEN : length;
        // For a full 1024-word copy the low bits are zero, so this wraps to 0x3FF as intended.
        len_m1  = len_sat[ADDR_W-1:0] - ONE;
`ifdef DPRAM_COPY_BACKWARD_EN
        descend = (dst_base > src_base);
`else
        descend = 1'b0;
`endif
        first_src = descend ? (src_base + len_m1) : src_base;
        first_dst = descend ? (dst_base + len_m1) : dst_base;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            en_a_reg     <= 1'b0;
            addr_a_reg   <= '0;
            data_a_reg   <= '0;
            rd_left_reg  <= '0;
            rd_valid_reg <= 1'b0;
            wr_addr_reg  <= '0;
            down_reg     <= 1'b0;
            en_b_reg     <= 1'b0;
            addr_b_reg   <= '0;
            data_b_reg   <= '0;
        end else begin
            en_a_reg   <= 1'b0;
            data_a_reg <= '0;
            done_reg   <= 1'b0;

            // A read is in flight exactly while RUN presents an address; out_A holds it one cycle later.
            rd_valid_reg <= (state_reg == RUN);
            en_b_reg     <= rd_valid_reg;
            if (rd_valid_reg) begin
                addr_b_reg  <= wr_addr_reg;
                data_b_reg  <= out_A;
                wr_addr_reg <= down_reg ? (wr_addr_reg - ONE) : (wr_addr_reg + ONE);
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_reg    <= 1'b1;
                        down_reg    <= descend;
                        addr_a_reg  <= first_src;
                        wr_addr_reg <= first_dst;
                        rd_left_reg <= len_m1;
                        state_reg   <= (len_sat != '0) ? RUN : DRAIN;
                    end
                end
                RUN: begin
                    if (rd_left_reg != '0) begin
                        addr_a_reg  <= down_reg ? (addr_a_reg - ONE) : (addr_a_reg + ONE);
                        rd_left_reg <= rd_left_reg - ONE;
                    end else begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!rd_valid_reg) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy   = busy_reg;
    assign done   = done_reg;
    assign en_A   = en_a_reg;
    assign addr_A = addr_a_reg;
    assign data_A = data_a_reg;
    assign en_B   = en_b_reg;
    assign addr_B = addr_b_reg;
    assign data_B = data_b_reg;

endmodule

// File: tb/tb_dpram_copy_engine.sv
// Bench for dpram_copy_engine: a behavioural dual-port RAM plus a memmove-style reference model.
module tb_dpram_copy_engine;

    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, en_A, en_B;
    logic [AW-1:0] addr_A, addr_B;
    logic [DW-1:0] data_A, data_B, out_A;

    logic [DW-1:0] mem [0:1023];
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // RAM model: registered read on A, write on B, plus a backdoor port for preloading.
    always @(posedge clk) begin
        out_A <= mem[addr_A];
        if (en_B)  mem[addr_B]  <= data_B;
        if (bd_we) mem[bd_addr] <= bd_data;
    end

    dpram_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_base(src_base), .dst_base(dst_base), .length(length),
        .busy(busy), .done(done),
        .en_A(en_A), .addr_A(addr_A), .data_A(data_A), .out_A(out_A),
        .en_B(en_B), .addr_B(addr_B), .data_B(data_B)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Runs one transfer. inject_cyc>0 pulses a stray start mid-transfer; rst_cyc>0 has reset sampled at that edge.
    task automatic run_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input logic [AW:0] len,
                            input int inject_cyc, input int rst_cyc, input string tag);
        int L, n_commit, cyc, n_wr, n_done_seen, tim_err, ord_err, mism, extra;
        bit back, got_done;
        logic [DW-1:0] snap [0:1023];
        logic [DW-1:0] expm [0:1023];
        logic [AW-1:0] exp_wr [$];
        logic [AW-1:0] exp_rd [$];
        logic [AW-1:0] a_s, a_d;

        L = (len > 11'd1024) ? 1024 : int'(len);
        back = 1'b0;
`ifdef DPRAM_COPY_BACKWARD_EN
        back = (dst > src);
`endif
        for (int j = 0; j < L; j++) begin
            int i;
            i = back ? (L - 1 - j) : j;
            exp_rd.push_back(src + 10'(i));
            exp_wr.push_back(dst + 10'(i));
        end
        n_commit = (rst_cyc > 0) ? ((rst_cyc - 2 < L) ? rst_cyc - 2 : L) : L;
        if (n_commit < 0) n_commit = 0;
        for (int k = 0; k < 1024; k++) begin
            snap[k] = mem[k];
            expm[k] = mem[k];
        end
        for (int j = 0; j < n_commit; j++) begin
            a_s = exp_rd[j];
            a_d = exp_wr[j];
            expm[a_d] = snap[a_s];
        end

        start = 1'b1; src_base = src; dst_base = dst; length = len;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_e0"}, busy, 1'b1);
        if (L > 0) check({tag, "_addrA_e0"}, addr_A, exp_rd[0]);

        cyc = 0; n_wr = 0; n_done_seen = 0; tim_err = 0; ord_err = 0; got_done = 1'b0;
        while (!got_done && cyc < L + 20) begin
            start = (inject_cyc > 0 && cyc == inject_cyc);
            if (start) begin
                src_base = 10'h300; dst_base = 10'h380; length = 11'd8;
            end
            if (rst_cyc > 0 && cyc == rst_cyc - 1) reset = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (rst_cyc > 0 && cyc == rst_cyc) begin
                check({tag, "_busy_after_rst"}, busy, 1'b0);
                check({tag, "_enB_after_rst"}, en_B, 1'b0);
                check({tag, "_done_after_rst"}, done, 1'b0);
                @(posedge clk); #1;
                reset = 1'b0;
                extra = 0;
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk); #1;
                    if (en_B || done || busy) extra++;
                end
                check({tag, "_quiet_after_rst"}, extra, 0);
                break;
            end
            start = 1'b0;
            if (busy !== ((L == 0) ? (cyc < 1) : (cyc < L + 2))) tim_err++;
            if (cyc < L && addr_A !== exp_rd[cyc]) tim_err++;
            if (en_B) begin
                if (n_wr >= L || addr_B !== exp_wr[n_wr]) ord_err++;
                n_wr++;
            end
            if (done) got_done = 1'b1;
        end

        if (rst_cyc == 0) begin
            check({tag, "_done_seen"}, got_done, 1'b1);
            check({tag, "_done_cycle"}, cyc, (L == 0) ? 1 : L + 2);
            check({tag, "_done_busy"}, busy, 1'b0);
            @(posedge clk); #1;
            check({tag, "_done_one_cycle"}, done, 1'b0);
            check({tag, "_enB_idle"}, en_B, 1'b0);
        end
        check({tag, "_n_writes"}, n_wr, n_commit);
        check({tag, "_timing_errs"}, tim_err, 0);
        check({tag, "_order_errs"}, ord_err, 0);
        mism = 0;
        for (int k = 0; k < 1024; k++) if (mem[k] !== expm[k]) mism++;
        check({tag, "_ram_mismatch"}, mism, 0);
        $display("copy %s src=%03h dst=%03h len=%0d cycles=%0d writes=%0d", tag, src, dst, len, cyc, n_wr);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_enA", en_A, 1'b0);
        check("rst_enB", en_B, 1'b0);
        check("rst_addrA", addr_A, 10'h000);
        check("rst_addrB", addr_B, 10'h000);
        check("rst_dataA", data_A, 16'h0000);
        check("rst_dataB", data_B, 16'h0000);
        reset = 1'b0;

        for (int k = 0; k < 1024; k++) bd_write(10'(k), 16'($urandom));

        for (int k = 0; k < 4; k++) bd_write(10'h010 + 10'(k), 16'hA001 + 16'(k));
        run_copy(10'h010, 10'h200, 11'd4, 0, 0, "basic");
        for (int k = 0; k < 4; k++) check("basic_word", mem[10'h200 + 10'(k)], 16'hA001 + 16'(k));

        run_copy(10'h050, 10'h060, 11'd0, 0, 0, "zero");

        bd_write(10'h3FE, 16'd1); bd_write(10'h3FF, 16'd2);
        bd_write(10'h000, 16'd3); bd_write(10'h001, 16'd4);
        run_copy(10'h3FE, 10'h100, 11'd4, 0, 0, "wrap");
        for (int k = 0; k < 4; k++) check("wrap_word", mem[10'h100 + 10'(k)], 16'(k + 1));

`ifdef DPRAM_COPY_BACKWARD_EN
        for (int k = 0; k < 8; k++) bd_write(10'h020 + 10'(k), 16'(k));
        run_copy(10'h020, 10'h022, 11'd6, 0, 0, "overlap");
        for (int k = 0; k < 6; k++) check("overlap_word", mem[10'h022 + 10'(k)], 16'(k));
`endif

        run_copy(10'h040, 10'h0C0, 11'd8, 3, 0, "busy_start");
        run_copy(10'h140, 10'h1C0, 11'd8, 0, 4, "reset_mid");
        run_copy(10'h123, 10'h123, 11'd1500, 0, 0, "saturate");

        for (int t = 0; t < 12; t++) begin
            int len_r, gap;
            logic [AW-1:0] s, d;
            len_r = $urandom_range(1, 64);
            gap   = $urandom_range(0, 1024 - 2 * len_r);
            s     = 10'($urandom);
            d     = s + 10'(len_r + gap);
            run_copy(s, d, 11'(len_r), 0, 0, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
